// File: rtl/data_memory_responder_if.sv
// Request/response bus between the CPU (master) and the data-memory responder (slave).
// Request side: valid/ready with write flag, byte address and store data.
// Response side: valid/ready with load data and an error flag.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    // CPU side
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_error
    );

    // Memory side
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_STATES idle
// cycles, performs a single word access into an internal array and holds the response
// until the CPU takes it.
// Optional macro DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN: reject addresses with addr[1:0] != 0
// (same response as an out-of-range access). Undefined: low address bits are ignored.
module data_memory_responder #(
    parameter int unsigned DATA_MEM_SIZE = 4096,
    parameter int unsigned WAIT_STATES   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned Depth   = DATA_MEM_SIZE / 4;
    localparam int unsigned IdxBits = (Depth > 1) ? $clog2(Depth) : 1;
    // Counter preload on request acceptance; unused when there are no wait states.
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q,  addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;
    logic [3:0]    cnt_q,   cnt_d;

    logic [31:0]   mem_q [Depth];
    logic [IdxBits-1:0] idx;
    logic          out_of_range;
    logic          reject;
    logic          mem_we;

    // Word index and rejection decode for the latched request.
    always_comb begin
        idx          = (Depth == 1) ? '0 : addr_q[IdxBits+1:2];
        out_of_range = (addr_q >= DATA_MEM_SIZE);
`ifdef DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN
        reject       = out_of_range || (addr_q[1:0] != 2'b00);
`else
        reject       = out_of_range;
`endif
    end

    // Next-state and datapath update for the request/wait/access/response sequence.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // req_ready is high whenever we are here out of reset.
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = StAccess;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                if (reject) begin
                    rdata_d = 32'd0;
                    error_d = 1'b1;
                end else if (write_q) begin
                    mem_we  = 1'b1;
                    rdata_d = 32'd0;
                    error_d = 1'b0;
                end else begin
                    rdata_d = mem_q[idx];
                    error_d = 1'b0;
                end
                state_d = StResp;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word array; contents survive reset, writes only happen in the access cycle.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held.
    assign bus.req_ready  = (state_q == StIdle) && reset;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed transactions with literal
// expectations plus a transaction-level model compared against the DUT every cycle.
module tb_data_memory_responder;

    localparam int unsigned SIZE = 4096;
    localparam int unsigned WS   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    data_memory_responder_if bus ();

    data_memory_responder #(
        .DATA_MEM_SIZE (SIZE),
        .WAIT_STATES   (WS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Word contents known to the bench, keyed by word index.
    logic [31:0] mdl_mem [int unsigned];
    bit          m_busy   = 1'b0;
    int          m_n      = 0;     // negedges seen since the handshake decision
    bit          m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_known;
    bit          idle_now;
    bit          resp_now;

    // Resolve the transaction the way the memory is defined to behave.
    task automatic model_access();
        bit          bad;
        int unsigned w;
        bad = (m_addr >= SIZE);
`ifdef DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN
        if (m_addr[1:0] != 2'b00) bad = 1'b1;
`endif
        w       = m_addr >> 2;
        m_err   = bad;
        m_rdata = 32'd0;
        m_known = 1'b1;
        if (!bad) begin
            if (m_write) begin
                mdl_mem[w] = m_wdata;
            end else if (mdl_mem.exists(w)) begin
                m_rdata = mdl_mem[w];
            end else begin
                m_known = 1'b0;
            end
        end
    endtask

    // Compare process: inputs change at posedge+1, so the negedge sees a stable picture.
    always @(negedge clock) begin
        if (!reset) begin
            m_busy = 1'b0;
            check("reset_req_ready",  bus.req_ready,  1'b0);
            check("reset_resp_valid", bus.resp_valid, 1'b0);
            check("reset_resp_rdata", bus.resp_rdata, 32'd0);
            check("reset_resp_error", bus.resp_error, 1'b0);
        end else begin
            if (m_busy) begin
                m_n++;
                // Access happens WS+1 edges after the handshake edge.
                if (m_n == int'(WS) + 2) model_access();
            end
            idle_now = !m_busy;
            resp_now = m_busy && (m_n >= int'(WS) + 2);
            check("req_ready",  bus.req_ready,  idle_now);
            check("resp_valid", bus.resp_valid, resp_now);
            if (resp_now) begin
                check("resp_error", bus.resp_error, m_err);
                if (m_known) check("resp_rdata", bus.resp_rdata, m_rdata);
            end
            if (resp_now && bus.resp_ready) begin
                m_busy = 1'b0;
            end else if (idle_now && bus.req_valid) begin
                m_busy  = 1'b1;
                m_n     = 0;
                m_write = bus.req_write;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One transaction; hold = cycles of response backpressure (0 = resp_ready high early).
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata, output logic err,
                          output int lat);
        int n;
        @(posedge clock); #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (hold == 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) check("req_accept_timeout", bus.req_ready, 1'b1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!bus.resp_valid && lat < 50);
        check("resp_arrival", bus.resp_valid, 1'b1);
        rdata = bus.resp_rdata;
        err   = bus.resp_error;
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            #1;
            check("backpressure_valid", bus.resp_valid, 1'b1);
            check("backpressure_rdata", bus.resp_rdata, rdata);
            bus.resp_ready = 1'b1;
            @(posedge clock); #1;
        end else begin
            @(posedge clock); #1;
        end
        bus.resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("idle_req_ready",  bus.req_ready,  1'b1);
        check("idle_resp_valid", bus.resp_valid, 1'b0);
        check("idle_resp_rdata", bus.resp_rdata, 32'd0);
        check("idle_resp_error", bus.resp_error, 1'b0);

        // Seed known contents.
        do_req(1'b1, 32'h0000_0000, 32'h1111_1111, 0, rd, er, lat);
        do_req(1'b1, 32'h0000_0020, 32'h5A5A_0001, 0, rd, er, lat);

        // Store then load, WAIT_STATES=2.
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("store_latency", lat, 4);
        check("store_rdata", rd, 32'd0);
        check("store_error", er, 1'b0);
        do_req(1'b0, 32'h0000_0010, 32'd0, 0, rd, er, lat);
        check("load_latency", lat, 4);
        check("load_rdata", rd, 32'hDEAD_BEEF);
        check("load_error", er, 1'b0);

        // Response backpressure.
        do_req(1'b0, 32'h0000_0010, 32'd0, 5, rd, er, lat);
        check("bp_rdata", rd, 32'hDEAD_BEEF);

        // Out of range store must not alias onto word 0.
        do_req(1'b1, 32'h0000_1000, 32'h1234_5678, 0, rd, er, lat);
        check("oor_error", er, 1'b1);
        check("oor_rdata", rd, 32'd0);
        do_req(1'b0, 32'h8000_0010, 32'd0, 0, rd, er, lat);
        check("oor_high_error", er, 1'b1);
        check("oor_high_rdata", rd, 32'd0);
        do_req(1'b0, 32'h0000_0000, 32'd0, 0, rd, er, lat);
        check("oor_word0_kept", rd, 32'h1111_1111);
        check("oor_word0_error", er, 1'b0);

        // Top word of the array.
        do_req(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, rd, er, lat);
        do_req(1'b0, 32'h0000_0FFC, 32'd0, 0, rd, er, lat);
        check("top_word_rdata", rd, 32'hCAFE_F00D);

        // Reset pulsed during WAIT: store must be dropped.
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        bus.req_wdata = 32'hA5A5_A5A5;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bus.req_ready && n < 50);
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("midreset_resp_valid", bus.resp_valid, 1'b0);
        check("midreset_req_ready",  bus.req_ready,  1'b1);
        do_req(1'b0, 32'h0000_0020, 32'd0, 0, rd, er, lat);
        check("midreset_old_value", rd, 32'h5A5A_0001);

        // Misaligned load.
        do_req(1'b0, 32'h0000_0012, 32'd0, 0, rd, er, lat);
`ifdef DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN
        check("misaligned_error", er, 1'b1);
        check("misaligned_rdata", rd, 32'd0);
`else
        check("misaligned_error", er, 1'b0);
        check("misaligned_rdata", rd, 32'hDEAD_BEEF);
`endif

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the CPU data-memory interface.
- Accepts one load/store request at a time from the CPU over a valid/ready handshake and applies a programmable number of wait states.
- Performs a word access into an internal word array, then returns read data (or write completion) over a response valid/ready handshake.
- Replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

Parameters:
- DATA_MEM_SIZE, 4096: memory size in bytes; word array depth = DATA_MEM_SIZE/4; must be a power of two and at least 4.
- WAIT_STATES, 2: number of idle cycles inserted between request acceptance and the access cycle; legal range 0..15.

Ports:
- clock  input  1  single clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_error  output  1  request was rejected (out of range, or misaligned when checking is enabled).

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE, req_ready=0 while reset is asserted, resp_valid=0, resp_rdata=0, resp_error=0.
  - Wait counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch req_write, req_addr and req_wdata.
  - If WAIT_STATES==0, go to ACCESS; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready=0; the request inputs are ignored.
  - Counter decrements each cycle; when counter==0, go to ACCESS.
- ACCESS (exactly one cycle):
  - req_ready=0. Word index = latched addr[log2(DATA_MEM_SIZE)-1:2].
  - Out of range (latched addr >= DATA_MEM_SIZE): no write; resp_rdata<=0; resp_error<=1.
  - Store: mem[index]<=wdata; resp_rdata<=0; resp_error<=0.
  - Load: resp_rdata<=mem[index]; resp_error<=0.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - When resp_ready=1, go to IDLE on the next edge, and resp_valid drops on that edge.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency: request handshake at edge T; resp_valid is high from edge T+WAIT_STATES+1, so it is first sampled at edge T+WAIT_STATES+2 when resp_ready=1.
- Throughput: one request per WAIT_STATES+3 cycles maximum.
- Address bits [1:0] are ignored for the access unless ALIGN_CHECK_EN is defined. Bits above the range are only used for the range check.
- Reset asserted mid-operation:
  - Abandons the transaction immediately.
  - If asserted before the ACCESS edge, no memory write occurs.
  - resp_valid is forced to 0.
- A store followed by a load to the same address returns the stored value; there are no forwarding hazards because transactions never overlap.
- resp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: DATA_MEMORY_RESPONDER_ALIGN_CHECK_EN.
- Defined: in ACCESS, a latched addr[1:0]!=0 is treated like out-of-range. There is no write, resp_rdata=0 and resp_error=1. This check takes priority together with the range check, with the same response.
- Undefined: addr[1:0] is ignored and misaligned addresses access the containing word.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
- Store then load, WAIT_STATES=2: store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 with resp_ready=1 -> each resp_valid is first sampled 4 edges after its handshake; load resp_rdata=0xDEADBEEF, resp_error=0.
- Response backpressure: load addr=0x10 with resp_ready=0 for 5 cycles -> resp_valid stays 1 and resp_rdata stays 0xDEADBEEF; req_ready=0 throughout; the handshake completes when resp_ready=1.
- Out of range: store addr=0x1000, wdata=0x12345678 (DATA_MEM_SIZE=4096) -> resp_error=1, resp_rdata=0; a later load of addr=0x0 returns its prior contents unchanged.
- Reset mid-operation: store addr=0x20, wdata=0xA5A5A5A5, with reset pulsed low during WAIT -> resp_valid=0 and req_ready=1 after release; a load of addr=0x20 returns the old value, not 0xA5A5A5A5.
- Alignment with the macro defined: load addr=0x12 -> resp_error=1, resp_rdata=0. With the macro undefined, the same load returns mem word 4 with resp_error=0.
